// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK up/down counter.
// Holds the JK action encoding ({j,k}) and default WIDTH/MODULUS constants.
package jk_pkg;

  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned MODULUS_DEF = 10;

  // JK input pair encoded as {j,k}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_act_e;

  // Action that forces a cell to the given bit value
  function automatic jk_act_e load_act(input logic b);
    return b ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_updown_counter_if.sv
// jk_updown_counter_if: control/data bundle of the JK up/down counter.
//   en, up, load, d : driven by the controlling block (master)
//   q, qb, tc, wrap : driven by the counter (slave)
interface jk_updown_counter_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, load, d,
    input  q, qb, tc, wrap
  );

  modport slave (
    input  en, up, load, d,
    output q, qb, tc, wrap
  );

endinterface

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop bit with asynchronous active-high clear.
//   clk, clr : clock, async clear (q -> 0)
//   j, k     : JK inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q, qb    : stored bit and its complement
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      unique case (jk_act_e'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        default:   q <= ~q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: loadable up/down counter built from WIDTH jk_cell bits.
//   clk, clr     : clock, async active-high clear
//   bus.en       : count enable         bus.up   : 1 = up, 0 = down
//   bus.load     : sync load of bus.d   bus.q/qb : count and its complement
//   bus.tc       : combinational terminal count (cascade carry)
//   bus.wrap     : registered one-cycle pulse after a wrap
// Optional macro JK_CNT_MODN_EN: count modulo MODULUS and clamp loads to MODULUS-1.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned MODULUS = MODULUS_DEF
) (
  input logic                clk,
  input logic                clr,
  jk_updown_counter_if.slave bus
);

`ifdef JK_CNT_MODN_EN
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam int unsigned unused_modulus = MODULUS;
`endif

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             wrap_q;

  // Target value for a count; the cells toggle wherever it differs from q
  always_comb begin
    q_nxt = q;
    if (bus.up) begin
      q_nxt = (q == MAX) ? '0 : q + WIDTH'(1);
    end else begin
      q_nxt = (q == '0) ? MAX : q - WIDTH'(1);
    end
  end

  // Load value, clamped into range when counting modulo MODULUS
  always_comb begin
    d_eff = bus.d;
`ifdef JK_CNT_MODN_EN
    if (bus.d > MAX) d_eff = MAX;
`endif
  end

  // Per-bit JK drive: load beats count beats hold
  always_comb begin
    j = '0;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.load) begin
        {j[i], k[i]} = load_act(d_eff[i]);
      end else if (bus.en && (q[i] != q_nxt[i])) begin
        {j[i], k[i]} = JK_TOGGLE;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .j   (j[g]),
      .k   (k[g]),
      .q   (q[g]),
      .qb  (qb[g])
    );
  end

  assign tc = bus.en & ~bus.load & ((bus.up & (q == MAX)) | (~bus.up & (q == '0)));

  // A wrap happens exactly on edges where tc was high
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign bus.q    = q;
  assign bus.qb   = qb;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter: directed self-checking bench for jk_updown_counter (WIDTH=4).
// Build with JK_CNT_MODN_EN defined to exercise the modulo-10 variant.
module tb_jk_updown_counter;

  localparam int unsigned W = 4;
`ifdef JK_CNT_MODN_EN
  localparam int unsigned MAXV = 9;
`else
  localparam int unsigned MAXV = 15;
`endif

  logic clk;
  logic clr;
  int   total;
  int   bad;
  int   exp_q;

  jk_updown_counter_if #(.WIDTH(W)) bus ();

  jk_updown_counter #(.WIDTH(W), .MODULUS(10)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] ones;
    ones = '1;
    clr = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.d = '0;
    #1;
    total++;
    if (bus.q !== 4'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", bus.q); end
    total++;
    if (bus.qb !== ones) begin bad++; $display("FAIL reset_qb got=%b want=%b", bus.qb, ones); end
    total++;
    if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", bus.wrap); end
    bus.en = 1'b1; bus.up = 1'b0;
    #1;
    total++;
    if (bus.tc !== 1'b1) begin bad++; $display("FAIL reset_tc_down got=%b want=1", bus.tc); end
    @(posedge clk); #1;
    total++;
    if (bus.q !== 4'd0 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL reset_hold q=%0d wrap=%b want q=0 wrap=0", bus.q, bus.wrap);
    end
    bus.en = 1'b1; bus.up = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic test_count_up();
    logic [W-1:0] e;
    exp_q = 0;
    for (int i = 0; i <= int'(MAXV); i++) begin
      total++;
      if (bus.tc !== (exp_q == int'(MAXV))) begin
        bad++; $display("FAIL up_tc q=%0d got=%b want=%b", exp_q, bus.tc, exp_q == int'(MAXV));
      end
      step();
      exp_q = (exp_q == int'(MAXV)) ? 0 : exp_q + 1;
      e = W'(exp_q);
      total++;
      if (bus.q !== e || bus.qb !== ~e) begin
        bad++; $display("FAIL up_q got=%0d/%b want=%0d/%b", bus.q, bus.qb, e, ~e);
      end
      total++;
      if (bus.wrap !== (exp_q == 0)) begin
        bad++; $display("FAIL up_wrap q=%0d got=%b want=%b", exp_q, bus.wrap, exp_q == 0);
      end
    end
  endtask

  task automatic test_count_down();
    bus.up = 1'b0;
    #1;
    total++;
    if (bus.tc !== 1'b1) begin bad++; $display("FAIL down_tc got=%b want=1", bus.tc); end
    step();
    total++;
    if (bus.q !== W'(MAXV) || bus.wrap !== 1'b1) begin
      bad++; $display("FAIL down_wrap q=%0d wrap=%b want q=%0d wrap=1", bus.q, bus.wrap, MAXV);
    end
    step();
    total++;
    if (bus.q !== W'(MAXV - 1) || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL down_next q=%0d wrap=%b want q=%0d wrap=0", bus.q, bus.wrap, MAXV - 1);
    end
  endtask

  task automatic test_load();
    bus.load = 1'b1; bus.d = 4'd9; bus.en = 1'b1; bus.up = 1'b1;
    step();
    total++;
    if (bus.q !== 4'd9 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL load9 q=%0d wrap=%b want q=9 wrap=0", bus.q, bus.wrap);
    end
    bus.load = 1'b0;
    step();
    exp_q = (MAXV == 9) ? 0 : 10;
    total++;
    if (bus.q !== W'(exp_q) || bus.wrap !== (MAXV == 9)) begin
      bad++; $display("FAIL load_then_count q=%0d wrap=%b want q=%0d wrap=%b",
                      bus.q, bus.wrap, exp_q, MAXV == 9);
    end
    bus.load = 1'b1; bus.d = W'(MAXV);
    step();
    bus.d = 4'd3;
    #1;
    total++;
    if (bus.tc !== 1'b0) begin bad++; $display("FAIL load_masks_tc got=%b want=0", bus.tc); end
    step();
    total++;
    if (bus.q !== 4'd3 || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL load_over_max q=%0d wrap=%b want q=3 wrap=0", bus.q, bus.wrap);
    end
    bus.d = 4'd13;
    step();
    exp_q = (13 > MAXV) ? int'(MAXV) : 13;
    total++;
    if (bus.q !== W'(exp_q)) begin
      bad++; $display("FAIL load_clamp got=%0d want=%0d", bus.q, exp_q);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_clr_mid();
    logic [W-1:0] ones;
    ones = '1;
    bus.load = 1'b1; bus.d = 4'd6; bus.en = 1'b1; bus.up = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    total++;
    if (bus.q !== 4'd7) begin bad++; $display("FAIL clr_pre got=%0d want=7", bus.q); end
    #1;
    clr = 1'b1;
    #1;
    total++;
    if (bus.q !== 4'd0 || bus.qb !== ones || bus.wrap !== 1'b0) begin
      bad++; $display("FAIL clr_async q=%0d qb=%b wrap=%b want q=0 qb=%b wrap=0",
                      bus.q, bus.qb, bus.wrap, ones);
    end
    #2;
    clr = 1'b0;
    step();
    total++;
    if (bus.q !== 4'd1) begin bad++; $display("FAIL clr_resume got=%0d want=1", bus.q); end
  endtask

  task automatic test_hold();
    bus.load = 1'b1; bus.d = 4'd6;
    step();
    bus.load = 1'b0; bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.up = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (bus.tc !== 1'b0) begin bad++; $display("FAIL hold_tc got=%b want=0", bus.tc); end
      step();
      total++;
      if (bus.q !== 4'd6 || bus.wrap !== 1'b0) begin
        bad++; $display("FAIL hold_q q=%0d wrap=%b want q=6 wrap=0", bus.q, bus.wrap);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_clr_mid();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
